l1_i_controller: RTL
====================

Name: l1_i_controller

Overview:
Control stage for the 2-way set-associative L1 instruction cache. It sits directly upstream of L1_I_data_array and drives that block's index_C_L1, offset, refill and way inputs. The block owns the tag/valid/LRU state, resolves each core fetch as a hit or a miss, and runs the L2 line-fill handshake. On a fill it pulses refill so the data array captures read_data_L2_L1.

Parameters:
TNUM, 21, tag bits (address[31 -: TNUM])
INUM, 26 - TNUM, index bits (address[6 +: INUM]); sets = 2**INUM
SETS, 2**INUM, number of sets (derived; do not override)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
read_C_L1  in  1  core fetch request
address_C_L1  in  32  fetch byte address; sampled only on accept
flush_C_L1  in  1  invalidate-all request (fence.i)
ready_L1_C  out  1  one-cycle pulse: fetch complete; data array output valid this cycle
busy_L1_C  out  1  high in every state except IDLE
index_C_L1  out  INUM  to data array; latched address[6 +: INUM]
offset  out  6  to data array; latched address[5:0]
refill  out  1  to data array; one-cycle write strobe
way  out  1  to data array; way selected for read or refill
read_L1_L2  out  1  line-fill request to L2; level signal
address_L1_L2  out  32  {tag, index, 6'd0}; line-aligned
ready_L2_L1  in  1  L2 response; read_data_L2_L1 is valid in this cycle

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; all valid bits, LRU bits, outputs and latched address go to 0. Tags need no reset.
- Reset applied mid-miss drops the transaction. read_L1_L2 is 0 from the next cycle. A ready_L2_L1 that arrives afterwards is ignored.
- States: IDLE, COMPARE, MISS, REFILL, FLUSH.
- IDLE:
  - flush_C_L1=1 -> FLUSH with the set counter at 0. Flush has priority over a simultaneous read_C_L1; the read must be re-presented.
  - else read_C_L1=1 -> latch address_C_L1 and go to COMPARE.
- COMPARE:
  - Read tag/valid of the latched set. hit_w = valid[w] && tag[w]==latched tag.
  - Hit: way=w, ready_L1_C=1 this cycle, LRU[set]=~w, then IDLE. Hit latency is 1 cycle after accept.
  - Both ways hitting is illegal; assert in simulation.
  - Miss: select the victim, then go to MISS.
    - Victim order: way0 if invalid; else way1 if invalid; else LRU[set].
    - Register the victim and hold it on `way` through REFILL.
- MISS: read_L1_L2=1 and address_L1_L2 is held stable until ready_L2_L1=1, then REFILL. Wait is unbounded.
- REFILL (exactly 1 cycle):
  - refill=1 and way=victim.
  - tag[victim]=latched tag, valid[victim]=1, LRU[set]=~victim.
  - Then COMPARE, which re-hits. Miss-to-ready latency is L2 wait + 2 cycles.
- FLUSH:
  - Clear valid[cnt][0..1] and LRU[cnt], one set per cycle.
  - After set SETS-1 (counter wraps), go to IDLE.
  - Requests during FLUSH are not accepted.
- refill is never high outside REFILL. read_L1_L2 is never high outside MISS.
- index_C_L1 and offset come from the latched address from COMPARE onward. In IDLE they follow address_C_L1.
- address_C_L1 changing after accept has no effect.

Decomposition:
- Package l1_i_pkg holds:
  - state enum l1_i_state_t {IDLE, COMPARE, MISS, REFILL, FLUSH}
  - TNUM/INUM defaults
  - the line-offset width constant (6)
- Sub-module l1_i_tag_array holds the tag/valid/LRU storage.
  - Ports: clk, rst, index, tag_in, we, way_we, lru_we, lru_in, clear_set.
  - Outputs: tag0/tag1, valid0/valid1, lru.
- The FSM and victim logic stay in l1_i_controller.

Test Plan:
- Cold miss: reset, then fetch 0x0000_1040 (index 1). read_L1_L2=1 with address_L1_L2=0x0000_1040. Drive ready_L2_L1 3 cycles later. Required: exactly one refill pulse with way=0, then ready_L1_C the cycle after REFILL+1.
- Hit: refetch 0x0000_1044. ready_L1_C one cycle after accept, way=0, no read_L1_L2.
- Second way and LRU:
  - Fetch 0x0000_2040 (same index, new tag): fill goes to way=1.
  - Refetch 0x0000_1040: hit way0, so LRU=1.
  - Fetch 0x0000_3040: victim way=1; 0x0000_1040 still hits.
- Stall during miss: hold ready_L2_L1=0 for 20 cycles. read_L1_L2 and address_L1_L2 stay constant, busy_L1_C=1, refill=0.
- Flush: fill sets 0..3, then assert flush_C_L1 together with read_C_L1. Required:
  - FLUSH lasts SETS=32 cycles.
  - The read is not accepted.
  - Refetching 0x0000_1040 afterwards misses.
- Reset mid-miss: rst during MISS. Next cycle read_L1_L2=0. A late ready_L2_L1 produces no refill and no valid bit is set.

Source files
------------

// File: rtl/l1_i_controller_pkg.sv
// Shared types and default geometry for the L1 instruction-cache control stage.
package l1_i_pkg;

  // Default tag width; the index takes what is left after tag and line offset.
  localparam int TNUM_DEF = 21;
  localparam int OFF_W    = 6;
  localparam int INUM_DEF = 32 - OFF_W - TNUM_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    MISS    = 3'd2,
    REFILL  = 3'd3,
    FLUSH   = 3'd4
  } l1_i_state_t;

endpackage

// File: rtl/l1_i_controller_if.sv
// Core fetch, data-array and L2 fill signals of the L1 instruction-cache controller.
// master = core / L2 side, slave = controller.
interface l1_i_controller_if #(
  parameter int INUM = l1_i_pkg::INUM_DEF
);

  // Core fetch side
  logic                       read_C_L1;
  logic [31:0]                address_C_L1;
  logic                       flush_C_L1;
  logic                       ready_L1_C;
  logic                       busy_L1_C;

  // Data array side
  logic [INUM-1:0]            index_C_L1;
  logic [l1_i_pkg::OFF_W-1:0] offset;
  logic                       refill;
  logic                       way;

  // L2 line-fill side
  logic                       read_L1_L2;
  logic [31:0]                address_L1_L2;
  logic                       ready_L2_L1;

  modport master (
    output read_C_L1, address_C_L1, flush_C_L1, ready_L2_L1,
    input  ready_L1_C, busy_L1_C, index_C_L1, offset, refill, way,
           read_L1_L2, address_L1_L2
  );

  modport slave (
    input  read_C_L1, address_C_L1, flush_C_L1, ready_L2_L1,
    output ready_L1_C, busy_L1_C, index_C_L1, offset, refill, way,
           read_L1_L2, address_L1_L2
  );

endinterface

// File: rtl/l1_i_controller_tag_array.sv
// Tag, valid and LRU storage for the 2-way L1 instruction cache.
// Reads are combinational on the presented index; writes land on the clock edge.
// lru holds the way to evict next for each set.
module l1_i_tag_array
  import l1_i_pkg::*;
#(
  parameter  int TNUM = TNUM_DEF,
  parameter  int INUM = INUM_DEF,
  localparam int SETS = 2 ** INUM
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [INUM-1:0] index,
  input  logic [TNUM-1:0] tag_in,
  input  logic            we,
  input  logic            way_we,
  input  logic            lru_we,
  input  logic            lru_in,
  input  logic            clear_set,
  output logic [TNUM-1:0] tag0,
  output logic [TNUM-1:0] tag1,
  output logic            valid0,
  output logic            valid1,
  output logic            lru
);

  logic [TNUM-1:0] tag0_mem [SETS];
  logic [TNUM-1:0] tag1_mem [SETS];
  logic [SETS-1:0] valid0_q;
  logic [SETS-1:0] valid1_q;
  logic [SETS-1:0] lru_q;

  // Tag write on refill; tags are meaningless while their valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      if (way_we) tag1_mem[index] <= tag_in;
      else        tag0_mem[index] <= tag_in;
    end
  end

  // Valid and LRU bits: cleared by reset or per-set flush, set/updated by refill and hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0_q <= '0;
      valid1_q <= '0;
      lru_q    <= '0;
    end else begin
      if (clear_set) begin
        valid0_q[index] <= 1'b0;
        valid1_q[index] <= 1'b0;
      end else if (we) begin
        if (way_we) valid1_q[index] <= 1'b1;
        else        valid0_q[index] <= 1'b1;
      end
      if (clear_set)   lru_q[index] <= 1'b0;
      else if (lru_we) lru_q[index] <= lru_in;
    end
  end

  assign tag0   = tag0_mem[index];
  assign tag1   = tag1_mem[index];
  assign valid0 = valid0_q[index];
  assign valid1 = valid1_q[index];
  assign lru    = lru_q[index];

endmodule

// File: rtl/l1_i_controller.sv
// Control stage of the 2-way set-associative L1 instruction cache: hit/miss
// resolution, victim choice, L2 line-fill handshake and fence.i flush walk.
module l1_i_controller
  import l1_i_pkg::*;
#(
  parameter  int TNUM = TNUM_DEF,
  parameter  int INUM = 32 - OFF_W - TNUM,
  localparam int SETS = 2 ** INUM
) (
  input  logic               clk,
  input  logic               rst,
  l1_i_controller_if.slave   bus
);

  l1_i_state_t     state;
  logic [31:0]     addr_q;
  logic            victim_q;
  logic [INUM-1:0] cnt_q;

  logic [TNUM-1:0] tag_l;
  logic [INUM-1:0] idx_l;
  logic [INUM-1:0] ta_index;
  logic [TNUM-1:0] tag0;
  logic [TNUM-1:0] tag1;
  logic            valid0;
  logic            valid1;
  logic            lru;
  logic            hit0;
  logic            hit1;
  logic            hit;
  logic            victim_c;
  logic            ta_we;
  logic            lru_we;
  logic            lru_in;
  logic            clear_set;

  assign tag_l = addr_q[31 -: TNUM];
  assign idx_l = addr_q[OFF_W +: INUM];

  assign hit0 = valid0 && (tag0 == tag_l);
  assign hit1 = valid1 && (tag1 == tag_l);
  assign hit  = hit0 || hit1;

  // Fill an empty way first (way0 before way1); only evict by LRU when the set is full.
  assign victim_c = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru);

  // Tag store control: the flush walk owns the index while it runs.
  always_comb begin
    ta_index  = (state == FLUSH) ? cnt_q : idx_l;
    ta_we     = (state == REFILL);
    clear_set = (state == FLUSH);
    lru_we    = (state == REFILL) || ((state == COMPARE) && hit);
    lru_in    = (state == REFILL) ? ~victim_q : ~hit1;
  end

  l1_i_tag_array #(
    .TNUM (TNUM),
    .INUM (INUM)
  ) u_tags (
    .clk       (clk),
    .rst       (rst),
    .index     (ta_index),
    .tag_in    (tag_l),
    .we        (ta_we),
    .way_we    (victim_q),
    .lru_we    (lru_we),
    .lru_in    (lru_in),
    .clear_set (clear_set),
    .tag0      (tag0),
    .tag1      (tag1),
    .valid0    (valid0),
    .valid1    (valid1),
    .lru       (lru)
  );

  // Main FSM; after a refill it returns to COMPARE so the fetch completes through the hit path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      victim_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.flush_C_L1) begin
            cnt_q <= '0;
            state <= FLUSH;
          end else if (bus.read_C_L1) begin
            addr_q <= bus.address_C_L1;
            state  <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            state <= IDLE;
          end else begin
            victim_q <= victim_c;
            state    <= MISS;
          end
        end
        MISS: begin
          if (bus.ready_L2_L1) state <= REFILL;
        end
        REFILL: begin
          state <= COMPARE;
        end
        FLUSH: begin
          cnt_q <= cnt_q + INUM'(1);
          if (cnt_q == INUM'(SETS - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two ways holding the same valid tag would mean the tag store is corrupt.
  always_ff @(posedge clk) begin
    if (!rst && state == COMPARE) begin
      assert (!(hit0 && hit1));
    end
  end

  assign bus.ready_L1_C    = (state == COMPARE) && hit;
  assign bus.busy_L1_C     = (state != IDLE);
  assign bus.index_C_L1    = (state == IDLE) ? bus.address_C_L1[OFF_W +: INUM] : idx_l;
  assign bus.offset        = (state == IDLE) ? bus.address_C_L1[OFF_W-1:0] : addr_q[OFF_W-1:0];
  assign bus.refill        = (state == REFILL);
  assign bus.way           = (state == COMPARE) ? hit1 :
                             ((state == MISS) || (state == REFILL)) ? victim_q : 1'b0;
  assign bus.read_L1_L2    = (state == MISS);
  assign bus.address_L1_L2 = {addr_q[31:OFF_W], {OFF_W{1'b0}}};

endmodule
